// File: rtl/result_uart_tx_pkg.sv
// Shared UART definitions for the Tiny CPU host link (TX and RX paths).
// FSM encoding, 8N1 frame constants and default bit timing.
package result_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;
    localparam int DEF_CLKS_PER_BIT = 868;   // 100 MHz / 115200
    localparam int DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/result_uart_tx_if.sv
// Controller/datapath-side bundle of the result transmitter.
// master = controller/datapath side, slave = result_uart_tx.
interface result_uart_tx_if;

    logic       Send_en_in;
    logic [7:0] Tx_Byte_in;
    logic       Tx_Serial_out;
    logic       Tx_Busy_out;
    logic       Fifo_Full_out;
    logic       Tx_Done_out;
    logic       Overflow_out;

    modport master (
        output Send_en_in, Tx_Byte_in,
        input  Tx_Serial_out, Tx_Busy_out, Fifo_Full_out, Tx_Done_out, Overflow_out
    );

    modport slave (
        input  Send_en_in, Tx_Byte_in,
        output Tx_Serial_out, Tx_Busy_out, Fifo_Full_out, Tx_Done_out, Overflow_out
    );

endinterface

// File: rtl/result_uart_tx_fifo.sv
// Small synchronous FIFO holding result bytes awaiting transmission.
// Head data is read combinationally so a pop can load the shifter on the same edge.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_head];

    // Full/empty gating uses the pre-edge count, so a push into a full FIFO
    // is dropped even when a pop happens in the same cycle.
    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;

    always_ff @(posedge CLK) begin
        if (w_wr)
            r_mem[r_tail] <= i_data;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_tail <= r_tail + 1'b1;
            if (w_rd)
                r_head <= r_head + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Result transmitter: queues datapath result bytes and sends each as an
// 8N1 UART frame, LSB first, with one IDLE cycle between frames.
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic           CLK,
    input  logic           RST,
    result_uart_tx_if.slave bus
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_t r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_line;
    logic          r_busy;
    logic          r_done;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    logic [7:0]    w_head;
    logic          w_push;
    logic          w_pop;
    logic          w_baud_last;
    logic          w_active_nxt;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (bus.Send_en_in),
        .i_pop   (w_pop),
        .i_data  (bus.Tx_Byte_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_push      = bus.Send_en_in && !w_full;
    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

    // Busy is registered from next-cycle values so it moves on the same edge
    // as the push/pop or final stop cycle that changes it.
    assign w_active_nxt = (r_state == IDLE) ? w_pop
                                            : !((r_state == STOP) && w_baud_last);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_line  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_busy <= w_active_nxt || (w_count_nxt != '0);
            r_ovf  <= r_ovf || (bus.Send_en_in && w_full);
            r_done <= (r_state == STOP) && (r_baud == BAUD_PRE);
            case (r_state)
                IDLE: begin
                    r_line <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_line  <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_line  <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_bit   <= '0;
                            r_line  <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_line  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Tx_Serial_out = r_line;
    assign bus.Tx_Busy_out   = r_busy;
    assign bus.Fifo_Full_out = w_full;
    assign bus.Tx_Done_out   = r_done;
    assign bus.Overflow_out  = r_ovf;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: pushes queue expected bytes, a monitor
// decodes frames from the TX line and checks bit timing and the done pulse.
module tb_result_uart_tx;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    result_uart_tx_if bus();

    result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dcnt  = 0;
    int frames = 0;
    int last_push_edge = 0;
    bit full_seen = 0;
    logic [7:0] exp_q [$];
    int start_q [$];

    // monitor state
    bit         m_act = 0;
    int         m_cnt = 0;
    int         m_d0  = 0;
    logic [7:0] m_byte = '0;
    logic [7:0] m_exp;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.Tx_Done_out) dcnt++;
        if (bus.Fifo_Full_out) full_seen = 1;
        if (!RST) begin
            m_act = 0;
        end else begin
            if (!m_act) begin
                if (bus.Tx_Done_out) begin
                    total++; bad++;
                    $display("FAIL done_stray: got=1 expected=0 (cyc %0d)", cyc);
                end
                if (bus.Tx_Serial_out == 1'b0) begin
                    m_act = 1; m_cnt = 0; m_byte = '0; m_d0 = dcnt;
                    start_q.push_back(cyc);
                end
            end else begin
                m_cnt++;
            end
            if (m_act) begin
                if (m_cnt % CPB == CPB/2) begin
                    if (m_cnt / CPB == 0)      chk("start_bit", bus.Tx_Serial_out, 0);
                    else if (m_cnt / CPB <= 8) m_byte[m_cnt/CPB - 1] = bus.Tx_Serial_out;
                    else                       chk("stop_bit", bus.Tx_Serial_out, 1);
                end
                if (m_cnt == 10*CPB - 1) begin
                    chk("done_pos", bus.Tx_Done_out, 1);
                    chk("done_once", dcnt - m_d0, 1);
                    chk("busy_at_done", bus.Tx_Busy_out, 1);
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_frame: got=%0h expected=none", m_byte);
                    end else begin
                        m_exp = exp_q.pop_front();
                        chk("frame_byte", m_byte, m_exp);
                    end
                    frames++;
                    m_act = 0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, input bit acc);
        @(negedge CLK);
        bus.Send_en_in = 1'b1;
        bus.Tx_Byte_in = b;
        last_push_edge = cyc + 1;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic release_bus();
        @(negedge CLK);
        bus.Send_en_in = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge CLK);
        while (bus.Tx_Busy_out && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_idle_timeout"}, (n >= 2000), 0);
        @(negedge CLK);
    endtask

    initial begin
        int n;
        int f0;
        int d0;
        bus.Send_en_in = 1'b0;
        bus.Tx_Byte_in = 8'h00;
        #23;
        chk("rst_line", bus.Tx_Serial_out, 1);
        chk("rst_busy", bus.Tx_Busy_out, 0);
        chk("rst_full", bus.Fifo_Full_out, 0);
        chk("rst_done", bus.Tx_Done_out, 0);
        chk("rst_ovf", bus.Overflow_out, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        // single byte: latency, busy drop after done
        start_q.delete();
        push(8'hA5, 1);
        release_bus();
        chk("push_busy", bus.Tx_Busy_out, 1);
        n = 0;
        while (!bus.Tx_Done_out && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("a5_done_seen", bus.Tx_Done_out, 1);
        @(negedge CLK);
        chk("a5_busy_fall", bus.Tx_Busy_out, 0);
        chk("a5_line_idle", bus.Tx_Serial_out, 1);
        chk("a5_start_lat", (start_q.size() > 0) ? start_q[0] : -1, last_push_edge + 1);

        // back-to-back
        start_q.delete();
        full_seen = 0;
        push(8'h01, 1);
        push(8'h02, 1);
        push(8'h03, 1);
        release_bus();
        wait_idle("b2b");
        chk("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("b2b_gap1", start_q[1] - start_q[0], 10*CPB + 1);
            chk("b2b_gap2", start_q[2] - start_q[1], 10*CPB + 1);
        end
        chk("b2b_full", full_seen, 0);

        // wrap-around: 10 bytes in bursts of 3
        f0 = frames;
        for (int i = 0; i < 10; i += 3) begin
            for (int j = i; j < i + 3 && j < 10; j++)
                push(8'h30 + 8'(j) * 8'h11, 1);
            release_bus();
            wait_idle("wrap");
        end
        chk("wrap_frames", frames - f0, 10);

        // overflow
        f0 = frames;
        full_seen = 0;
        for (int i = 0; i < 6; i++)
            push(8'h10 + 8'(i), (i < 5));
        release_bus();
        chk("ovf_set", bus.Overflow_out, 1);
        wait_idle("ovf");
        chk("ovf_sticky", bus.Overflow_out, 1);
        chk("ovf_full_seen", full_seen, 1);
        chk("ovf_frames", frames - f0, 5);
        chk("q_empty", exp_q.size(), 0);

        // reset mid-frame
        push(8'hFF, 1);
        release_bus();
        repeat (CPB + 4) @(negedge CLK);
        d0 = dcnt;
        #2 RST = 1'b0;
        #1;
        chk("mrst_line", bus.Tx_Serial_out, 1);
        chk("mrst_busy", bus.Tx_Busy_out, 0);
        chk("mrst_full", bus.Fifo_Full_out, 0);
        chk("mrst_done", bus.Tx_Done_out, 0);
        chk("mrst_ovf", bus.Overflow_out, 0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (12*CPB) @(negedge CLK);
        chk("mrst_no_done", dcnt - d0, 0);
        chk("mrst_line_after", bus.Tx_Serial_out, 1);
        chk("mrst_busy_after", bus.Tx_Busy_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
